// File: rtl/tsip_time_parser.sv
// TSIP framing decoder: extracts time-of-day from Primary Timing packets (0x8F-AB) and
// publishes it with a one-cycle strobe; anything malformed leaves the published time untouched.
module tsip_time_parser #(
  parameter logic [7:0]  TSIP_ID      = 8'h8F,
  parameter logic [7:0]  TSIP_SUBCODE = 8'hAB,
  parameter int unsigned PKT_LEN      = 17,
  parameter int unsigned TIMEOUT_CLKS = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic        o_thunder_packet_dv,
  output logic [15:0] o_thunder_year,
  output logic [7:0]  o_thunder_month,
  output logic [7:0]  o_thunder_day,
  output logic [7:0]  o_thunder_hour,
  output logic [7:0]  o_thunder_minutes,
  output logic [7:0]  o_thunder_seconds,
  output logic [7:0]  o_timing_flag,
  output logic        o_pkt_err
);

  localparam int unsigned IDX_W = $clog2(PKT_LEN + 2);
  localparam int unsigned TMO_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [IDX_W-1:0] IDX_LEN = IDX_W'(PKT_LEN);
  localparam logic [IDX_W-1:0] IDX_SAT = IDX_W'(PKT_LEN + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] DLE = 8'h10;
  localparam logic [7:0] ETX = 8'h03;

  typedef enum logic [2:0] {StIdle, StId, StData, StDataDle, StSkip, StSkipDle} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [TMO_W-1:0] tmo_q;
  logic [7:0]       sh_sub_q, sh_flag_q, sh_sec_q, sh_min_q, sh_hour_q;
  logic [7:0]       sh_day_q, sh_mon_q, sh_yhi_q, sh_ylo_q;

  logic data_wr, frame_ok, timed;

  // A byte following DLE is interpreted as a packet ID, both at frame start and on resync.
  function automatic state_e id_next(input logic [7:0] b);
    if (b == TSIP_ID)  return StData;
    else if (b == ETX) return StIdle;
    else if (b == DLE) return StId;
    else               return StSkip;
  endfunction

  always_comb begin
    data_wr  = i_rx_dv && (((state_q == StData) && (i_rx_byte != DLE)) ||
                           ((state_q == StDataDle) && (i_rx_byte == DLE)));
    frame_ok = (idx_q == IDX_LEN) && (sh_sub_q == TSIP_SUBCODE);
    timed    = (state_q == StData) || (state_q == StDataDle) ||
               (state_q == StSkip) || (state_q == StSkipDle);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q             <= StIdle;
      idx_q               <= '0;
      tmo_q               <= '0;
      sh_sub_q            <= '0;
      sh_flag_q           <= '0;
      sh_sec_q            <= '0;
      sh_min_q            <= '0;
      sh_hour_q           <= '0;
      sh_day_q            <= '0;
      sh_mon_q            <= '0;
      sh_yhi_q            <= '0;
      sh_ylo_q            <= '0;
      o_thunder_packet_dv <= 1'b0;
      o_thunder_year      <= '0;
      o_thunder_month     <= '0;
      o_thunder_day       <= '0;
      o_thunder_hour      <= '0;
      o_thunder_minutes   <= '0;
      o_thunder_seconds   <= '0;
      o_timing_flag       <= '0;
      o_pkt_err           <= 1'b0;
    end else begin
      o_thunder_packet_dv <= 1'b0;
      o_pkt_err           <= 1'b0;

      if (data_wr) begin
        if (idx_q < IDX_LEN) begin
          case (idx_q)
            IDX_W'(0):  sh_sub_q  <= i_rx_byte;
            IDX_W'(9):  sh_flag_q <= i_rx_byte;
            IDX_W'(10): sh_sec_q  <= i_rx_byte;
            IDX_W'(11): sh_min_q  <= i_rx_byte;
            IDX_W'(12): sh_hour_q <= i_rx_byte;
            IDX_W'(13): sh_day_q  <= i_rx_byte;
            IDX_W'(14): sh_mon_q  <= i_rx_byte;
            IDX_W'(15): sh_yhi_q  <= i_rx_byte;
            IDX_W'(16): sh_ylo_q  <= i_rx_byte;
            default: ;
          endcase
        end
        if (idx_q != IDX_SAT) idx_q <= idx_q + 1'b1;
      end

      if (i_rx_dv) begin
        tmo_q <= '0;
        case (state_q)
          StIdle: if (i_rx_byte == DLE) state_q <= StId;
          StId: begin
            state_q <= id_next(i_rx_byte);
            idx_q   <= '0;
          end
          StData: if (i_rx_byte == DLE) state_q <= StDataDle;
          StDataDle: begin
            if (i_rx_byte == DLE) begin
              state_q <= StData;
            end else if (i_rx_byte == ETX) begin
              state_q <= StIdle;
              if (frame_ok) begin
                o_thunder_packet_dv <= 1'b1;
                o_thunder_year      <= {sh_yhi_q, sh_ylo_q};
                o_thunder_month     <= sh_mon_q;
                o_thunder_day       <= sh_day_q;
                o_thunder_hour      <= sh_hour_q;
                o_thunder_minutes   <= sh_min_q;
                o_thunder_seconds   <= sh_sec_q;
                o_timing_flag       <= sh_flag_q;
              end else begin
                o_pkt_err <= 1'b1;
              end
            end else begin
              o_pkt_err <= 1'b1;
              state_q   <= id_next(i_rx_byte);
              idx_q     <= '0;
            end
          end
          StSkip: if (i_rx_byte == DLE) state_q <= StSkipDle;
          StSkipDle: begin
            if (i_rx_byte == ETX)      state_q <= StIdle;
            else if (i_rx_byte == DLE) state_q <= StSkip;
            else begin
              state_q <= id_next(i_rx_byte);
              idx_q   <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end else if (timed) begin
        if (tmo_q == TMO_MAX) begin
          state_q   <= StIdle;
          tmo_q     <= '0;
          // Only a stalled 0x8F candidate is reported; stalled foreign packets drop silently.
          o_pkt_err <= (state_q == StData) || (state_q == StDataDle);
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tsip_time_parser.sv
// Self-checking bench for tsip_time_parser: scoreboard of expected commits/errors with
// exact one-cycle latency checks.
module tb_tsip_time_parser;

  localparam int unsigned TMO = 50;

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minutes;
    logic [7:0]  seconds;
    logic [7:0]  flag;
  } tod_t;

  typedef struct {
    bit     err;
    tod_t   t;
    longint due;
  } exp_t;

  typedef logic [7:0] bytes_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        pkt_dv, pkt_err;
  logic [15:0] year;
  logic [7:0]  month, day, hour, minutes, seconds, flag;
  tod_t        act;

  exp_t   exp_q[$];
  tod_t   cur = '0;
  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;

  tsip_time_parser #(
    .TSIP_ID      (8'h8F),
    .TSIP_SUBCODE (8'hAB),
    .PKT_LEN      (17),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_rx_dv             (rx_dv),
    .i_rx_byte           (rx_byte),
    .o_thunder_packet_dv (pkt_dv),
    .o_thunder_year      (year),
    .o_thunder_month     (month),
    .o_thunder_day       (day),
    .o_thunder_hour      (hour),
    .o_thunder_minutes   (minutes),
    .o_thunder_seconds   (seconds),
    .o_timing_flag       (flag),
    .o_pkt_err           (pkt_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign act = {year, month, day, hour, minutes, seconds, flag};

  // Scoreboard: every strobe must match the head of the expected queue, in kind, cycle and value.
  always @(negedge clk) begin
    exp_t e;
    tod_t req;
    if (!rst) begin
      if (pkt_dv && pkt_err) begin
        checks++;
        failures++;
        $display("FAIL both_strobes dv=1 err=1 at cycle %0d, required at most one", cyc);
      end else if (pkt_dv || pkt_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event dv=%0b err=%0b at cycle %0d, required none",
                   pkt_dv, pkt_err, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.err != pkt_err || e.due != cyc) begin
            failures++;
            $display("FAIL event_kind_time got err=%0b cycle=%0d, required err=%0b cycle=%0d",
                     pkt_err, cyc, e.err, e.due);
          end
          req = e.err ? cur : e.t;
          checks++;
          if (act !== req) begin
            failures++;
            $display("FAIL event_outputs got %h, required %h", act, req);
          end
          if (!e.err) cur = e.t;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bytes_t mk_body(input logic [7:0] sub, input int len, input tod_t t);
    bytes_t q;
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      case (i)
        0:  b = sub;
        9:  b = t.flag;
        10: b = t.seconds;
        11: b = t.minutes;
        12: b = t.hour;
        13: b = t.day;
        14: b = t.month;
        15: b = t.year[15:8];
        16: b = t.year[7:0];
        default: ;
      endcase
      q.push_back(b);
    end
    return q;
  endfunction

  // Stuffed body followed by DLE ETX.
  task automatic send_body(input bytes_t body);
    foreach (body[i]) begin
      if (body[i] == 8'h10) send_byte(8'h10);
      send_byte(body[i]);
    end
    send_byte(8'h10);
    send_byte(8'h03);
  endtask

  task automatic send_frame(input logic [7:0] id, input bytes_t body);
    send_byte(8'h10);
    send_byte(id);
    send_body(body);
  endtask

  task automatic push_commit(input tod_t t);
    exp_t e;
    e.err = 1'b0;
    e.t   = t;
    e.due = cyc;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input longint due);
    exp_t e;
    e.err = 1'b1;
    e.t   = '0;
    e.due = due;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_pending got %0d outstanding events, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    checks++;
    if ({act, pkt_dv, pkt_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got %h dv=%0b err=%0b, required all 0", act, pkt_dv, pkt_err);
    end
  endtask

  task automatic test_nominal();
    tod_t t;
    t = {16'h07E8, 8'h06, 8'h0F, 8'h0C, 8'h2D, 8'h1E, 8'h03};
    send_frame(8'h8F, mk_body(8'hAB, 17, t));
    push_commit(t);
    drain("nominal");
    checks++;
    if (act !== {16'd2024, 8'd6, 8'd15, 8'd12, 8'd45, 8'd30, 8'd3}) begin
      failures++;
      $display("FAIL nominal_values got %h, required year 2024 6/15 12:45:30 flag 3", act);
    end
  endtask

  task automatic test_stuffing();
    tod_t t;
    t = {16'h1010, 8'h07, 8'h10, 8'h0D, 8'h2E, 8'h10, 8'h10};
    send_frame(8'h8F, mk_body(8'hAB, 17, t));
    push_commit(t);
    drain("stuffing");
  endtask

  task automatic test_foreign();
    tod_t t;
    t = {16'h07E9, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_frame(8'h47, mk_body(8'hAB, 17, {16'h0BAD, 8'h0B, 8'h0A, 8'h0D, 8'h0E, 8'h0F, 8'h01}));
    send_frame(8'h8F, mk_body(8'hAB, 17, t));
    push_commit(t);
    drain("foreign");
  endtask

  task automatic test_malformed();
    tod_t t;
    t = {16'h0FFF, 8'h0C, 8'h1F, 8'h17, 8'h3B, 8'h3B, 8'h0F};
    send_frame(8'h8F, mk_body(8'hAC, 17, t));
    push_err(cyc);
    drain("bad_subcode");
    send_frame(8'h8F, mk_body(8'hAB, 16, t));
    push_err(cyc);
    drain("truncated");
    send_frame(8'h8F, mk_body(8'hAB, 18, t));
    push_err(cyc);
    drain("too_long");
  endtask

  task automatic test_resync();
    tod_t t;
    t = {16'h07EA, 8'h02, 8'h1C, 8'h16, 8'h00, 8'h3A, 8'h02};
    send_byte(8'h10);
    send_byte(8'h8F);
    send_byte(8'hAB);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h8F);
    push_err(cyc);
    send_body(mk_body(8'hAB, 17, t));
    push_commit(t);
    drain("resync");
  endtask

  task automatic test_timeout();
    tod_t t;
    t = {16'h0800, 8'h0B, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04};
    send_byte(8'h10);
    send_byte(8'h8F);
    send_byte(8'hAB);
    push_err(cyc + TMO);
    idle(TMO + 5);
    send_frame(8'h8F, mk_body(8'hAB, 17, t));
    push_commit(t);
    drain("timeout");
  endtask

  task automatic test_reset_mid();
    tod_t t;
    t = {16'h07E8, 8'h0A, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05};
    send_byte(8'h10);
    send_byte(8'h8F);
    send_byte(8'hAB);
    send_byte(8'h01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur = '0;
    checks++;
    if ({act, pkt_dv, pkt_err} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got %h dv=%0b err=%0b, required all 0",
               act, pkt_dv, pkt_err);
    end
    send_frame(8'h8F, mk_body(8'hAB, 17, t));
    push_commit(t);
    drain("reset_mid");
  endtask

  task automatic test_back_to_back();
    tod_t a, b;
    a = {16'h07E8, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    b = {16'h07E8, 8'h03, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01};
    send_frame(8'h8F, mk_body(8'hAB, 17, a));
    push_commit(a);
    send_frame(8'h8F, mk_body(8'hAB, 17, b));
    push_commit(b);
    drain("back_to_back");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_nominal();
    test_stuffing();
    test_foreign();
    test_malformed();
    test_resync();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
